// File: rtl/input_delay_pkg.sv
// input_delay_pkg -- shared definitions for the input_delay_reduce pipeline.
//   mode_e        : reduction op encoding carried down the pipeline
//   clog2_f       : ceil(log2(n)), the reduction tree depth
//   op_identity   : padding value that leaves the active op's result unchanged
//   level_count   : number of lanes at a given tree level
//   level_offset  : lane offset of a tree level inside the flattened level bus
package input_delay_pkg;

  typedef enum logic [1:0] {
    MODE_AND  = 2'b00,
    MODE_OR   = 2'b01,
    MODE_XOR  = 2'b10,
    MODE_PASS = 2'b11
  } mode_e;

  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // All-ones for AND, zero for OR/XOR. PASS never looks at the right operand.
  function automatic logic [31:0] op_identity(input mode_e m);
    return (m == MODE_AND) ? 32'hFFFF_FFFF : 32'h0000_0000;
  endfunction

  // Each level halves the lane count, rounding up (odd lanes get a padded partner).
  function automatic int level_count(input int n, input int lvl);
    int c;
    c = n;
    for (int i = 0; i < lvl; i++) c = (c + 1) / 2;
    return c;
  endfunction

  function automatic int level_offset(input int n, input int lvl);
    int s;
    s = 0;
    for (int i = 0; i < lvl; i++) s += level_count(n, i);
    return s;
  endfunction

endpackage

// File: rtl/reduce_stage.sv
// reduce_stage -- one registered level of the reduction tree.
// Combines lanes (2k, 2k+1) with the op carried alongside the sample; an odd
// last lane is paired with the op identity. Data and mode load only on a valid
// sample so the final stage holds its result while idle.
// Ports:
//   clk1, rst_n   clock, asynchronous active-low reset
//   in_data       N_IN lanes of DATA_W bits, lane k at [k*DATA_W +: DATA_W]
//   in_mode       reduction op (mode_e encoding) of the sample
//   in_valid      sample valid
//   out_data      ceil(N_IN/2) registered lanes
//   out_mode      registered op travelling with the sample
//   out_valid     registered valid
module reduce_stage
  import input_delay_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int DATA_W = 8
) (
  input  logic                            clk1,
  input  logic                            rst_n,
  input  logic [N_IN*DATA_W-1:0]          in_data,
  input  logic [1:0]                      in_mode,
  input  logic                            in_valid,
  output logic [((N_IN+1)/2)*DATA_W-1:0]  out_data,
  output logic [1:0]                      out_mode,
  output logic                            out_valid
);

  localparam int N_OUT = (N_IN + 1) / 2;

  mode_e op;
  assign op = mode_e'(in_mode);

  function automatic logic [DATA_W-1:0] combine(input mode_e m,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    case (m)
      MODE_AND: combine = a & b;
      MODE_OR:  combine = a | b;
      MODE_XOR: combine = a ^ b;
      default:  combine = a;  // lane 0 is always the leftmost operand
    endcase
  endfunction

  logic [N_OUT*DATA_W-1:0] pair_result;

  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_pair
    logic [DATA_W-1:0] right;
    if (2 * gi + 1 < N_IN) begin : g_full
      assign right = in_data[(2*gi+1)*DATA_W +: DATA_W];
    end else begin : g_pad
      assign right = DATA_W'(op_identity(op));
    end
    assign pair_result[gi*DATA_W +: DATA_W] =
      combine(op, in_data[2*gi*DATA_W +: DATA_W], right);
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_mode  <= 2'b00;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= pair_result;
        out_mode <= in_mode;
      end
    end
  end

endmodule

// File: rtl/input_delay_reduce.sv
// input_delay_reduce -- captures NUM_CH input channels in a bare register
// stage, then reduces them (AND / OR / XOR / pass channel 0) through a
// pipelined binary tree, one register per level. Latency 1 + ceil(log2(NUM_CH)).
// Optional feature macro: INPUT_DELAY_REFPIN_EN adds the ref_q toggle flop.
// Ports:
//   clk1       single clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   sample valid
//   mode       00 AND, 01 OR, 10 XOR, 11 pass channel 0
//   in_data    NUM_CH channels, channel k at [k*DATA_W +: DATA_W]
//   ref_q      (INPUT_DELAY_REFPIN_EN only) toggles every clk1 edge
//   out_data   reduced result, held while out_valid is low
//   out_valid  result valid
//   out_count  saturating count of delivered results
module input_delay_reduce
  import input_delay_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8
) (
  input  logic                     clk1,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [1:0]               mode,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
`ifdef INPUT_DELAY_REFPIN_EN
  output logic                     ref_q,
`endif
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  output logic [15:0]              out_count
);

  localparam int DEPTH    = clog2_f(NUM_CH);
  localparam int TOTAL_CH = level_offset(NUM_CH, DEPTH + 1);
  localparam int LAST_OFF = level_offset(NUM_CH, DEPTH);

  // Capture stage: inputs go straight into flops so the input-delay budget
  // sees only a flop setup time.
  logic [NUM_CH*DATA_W-1:0] cap_data_reg;
  logic [1:0]               cap_mode_reg;
  logic                     cap_valid_reg;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      cap_data_reg  <= '0;
      cap_mode_reg  <= 2'b00;
      cap_valid_reg <= 1'b0;
    end else begin
      cap_data_reg  <= in_data;
      cap_mode_reg  <= mode;
      cap_valid_reg <= in_valid;
    end
  end

  // All tree levels share one flattened bus; level l starts at lane
  // level_offset(NUM_CH, l) and is level_count(NUM_CH, l) lanes wide.
  wire [TOTAL_CH*DATA_W-1:0] lvl_data;
  wire [DEPTH:0][1:0]        lvl_mode;
  wire [DEPTH:0]             lvl_valid;

  assign lvl_data[NUM_CH*DATA_W-1:0] = cap_data_reg;
  assign lvl_mode[0]                 = cap_mode_reg;
  assign lvl_valid[0]                = cap_valid_reg;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_level
    localparam int N_IN    = level_count(NUM_CH, gi);
    localparam int IN_OFF  = level_offset(NUM_CH, gi);
    localparam int OUT_OFF = level_offset(NUM_CH, gi + 1);

    reduce_stage #(
      .N_IN   (N_IN),
      .DATA_W (DATA_W)
    ) u_stage (
      .clk1      (clk1),
      .rst_n     (rst_n),
      .in_data   (lvl_data[IN_OFF*DATA_W +: N_IN*DATA_W]),
      .in_mode   (lvl_mode[gi]),
      .in_valid  (lvl_valid[gi]),
      .out_data  (lvl_data[OUT_OFF*DATA_W +: ((N_IN+1)/2)*DATA_W]),
      .out_mode  (lvl_mode[gi+1]),
      .out_valid (lvl_valid[gi+1])
    );
  end

  assign out_data  = lvl_data[LAST_OFF*DATA_W +: DATA_W];
  assign out_valid = lvl_valid[DEPTH];

  // The mode leaving the last level has no consumer.
  wire [1:0] unused_final_mode;
  assign unused_final_mode = lvl_mode[DEPTH];

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      out_count <= 16'h0000;
    end else if (out_valid && (out_count != 16'hFFFF)) begin
      out_count <= out_count + 16'd1;
    end
  end

`ifdef INPUT_DELAY_REFPIN_EN
  // Free-running toggle used as a timing reference point.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      ref_q <= 1'b0;
    end else begin
      ref_q <= ~ref_q;
    end
  end
`endif

endmodule

// File: doc/input_delay_reduce.md
INPUT_DELAY_REDUCE -- requirements
Module: input_delay_reduce

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of captured input channels (legal 2..16).
REQ-002 SHALL have parameter DATA_W, default 8, meaning width of each channel in bits (legal 1..32).
REQ-003 SHALL have port clk1  input  1  the single clock; all flops are rising-edge on clk1.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  marks in_data/mode as a sample to capture this cycle.
REQ-006 SHALL have port mode  input  2  reduction op: 00 AND, 01 OR, 10 XOR, 11 pass channel 0.
REQ-007 SHALL have port in_data  input  NUM_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
REQ-008 SHALL have port out_data  output  DATA_W  reduced result.
REQ-009 SHALL have port out_valid  output  1  out_data holds a result this cycle.
REQ-010 SHALL have port out_count  output  16  saturating count of results delivered.

Function
REQ-011 SHALL register in_data, mode and in_valid in one capture stage on every clk1 edge, with no combinational logic before the capture flops.
REQ-012 SHALL reduce the captured channels through a binary tree of depth D = ceil(log2(NUM_CH)), with one register stage per tree level.
REQ-013 SHALL have latency L = 1 + D cycles from in_valid high to out_valid high, i.e. 3 cycles for NUM_CH=4 and 5 cycles for NUM_CH=16.
REQ-014 SHALL accept one sample per cycle with no back-pressure; back-to-back samples SHALL emerge back-to-back.
REQ-015 SHALL carry mode down the pipeline alongside its sample, so a mode change mid-flight never affects in-flight results.
REQ-016 SHALL pad missing leaves when NUM_CH is not a power of two with the identity of the active op: all-ones for AND, zero for OR and XOR.
REQ-017 SHALL, in mode 11, output channel 0 unchanged after the same latency L.
REQ-018 SHALL hold out_data at its last value while out_valid is low.
REQ-019 SHALL increment out_count on each cycle with out_valid high, saturating at 16'hFFFF with no wrap.

Reset
REQ-020 SHALL, while rst_n is low, asynchronously force all capture, tree and output registers to zero, out_valid to 0 and out_count to 0.
REQ-021 SHALL discard samples that are in flight when reset asserts; no out_valid SHALL appear for them after release.
REQ-022 SHALL capture the first sample on the first rising clk1 edge after rst_n deasserts.

Configuration
REQ-023 SHALL, when macro INPUT_DELAY_REFPIN_EN is defined, add output ref_q (1 bit) from a flop that toggles on every clk1 edge and resets to 0, for use as a -reference_pin timing point.
REQ-024 SHALL, without INPUT_DELAY_REFPIN_EN, omit the ref_q port and its flop entirely, with all other behaviour unchanged.

Structure
REQ-025 SHALL place in shared package input_delay_pkg: the mode enum (MODE_AND, MODE_OR, MODE_XOR, MODE_PASS), the op-identity function and the ceil-log2 constant function.
REQ-026 SHALL implement each tree level as one instance of sub-module reduce_stage, parameterised by input count and DATA_W, which pairwise-combines its inputs and registers data, mode and valid.

Verification
REQ-027 SHALL cover: NUM_CH=4, DATA_W=8, mode 00, channels {FF,F0,3C,FF}, in_valid pulse -> out_data=30 with out_valid high exactly 3 cycles later.
REQ-028 SHALL cover: mode 10 on channels {01,02,04,08} followed by mode 01 on {00,00,00,80} on consecutive cycles -> out_data=0F then 80 on consecutive cycles.
REQ-029 SHALL cover: NUM_CH=3, mode 00, channels {AA,FF,0F} -> out_data=0A, confirming all-ones padding.
REQ-030 SHALL cover: rst_n pulsed low while 2 samples are in flight -> out_valid stays 0, out_count=0, and the next sample after release emerges with latency L.
REQ-031 SHALL cover: out_count preloaded near saturation, then 70000 valid samples -> out_count holds FFFF.
REQ-032 SHALL cover: build with INPUT_DELAY_REFPIN_EN -> ref_q reads 0,1,0,1 on successive edges after reset; build without it -> port absent and all other results identical.
